// File: rtl/codificador_serial.sv
// Serial frame encoder: sends a control or status byte to the UART whenever the
// observed values differ from the last acknowledged ones, with retry on timeout.
`timescale 1ns/1ps
module codificador_serial #(
    parameter int TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       reset_sistema,
    input  logic       emergencia,
    input  logic [2:0] andar,
    input  logic [3:0] estado,
    input  logic       solicita_status,
    input  logic       tx_ocupado,
    input  logic       pronto_tx,
    output logic [7:0] dados_tx,
    output logic       partida_tx,
    output logic       ocupado,
    output logic [7:0] quadros_enviados,
    output logic       erro_timeout
);

    typedef enum logic {
        OCIOSO = 1'b0,
        ESPERA = 1'b1
    } fsm_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    fsm_t          fsm_q, fsm_d;
    logic [7:0]    dados_tx_q, dados_tx_d;
    logic          partida_tx_q, partida_tx_d;
    logic          ocupado_q, ocupado_d;
    logic [7:0]    quadros_q, quadros_d;
    logic          erro_q, erro_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ult_ctrl_q, ult_ctrl_d;
    logic [2:0]    ult_andar_q, ult_andar_d;
    logic [3:0]    ult_estado_q, ult_estado_d;
    logic          pend_q, pend_d;

    logic [2:0]    ctrl_atual_s;
    logic [7:0]    quadro_ctrl_s;
    logic [7:0]    quadro_status_s;
    logic          dif_ctrl_s;
    logic          dif_status_s;
    logic          limpa_pend_s;

    // Frame images and difference detection against the last acknowledged values
    always_comb begin
        ctrl_atual_s    = {emergencia, reset_sistema, iniciar};
        quadro_ctrl_s   = {1'b1, 2'b00, emergencia, 1'b0, reset_sistema, 1'b0, iniciar};
        quadro_status_s = {1'b0, andar, estado};
        dif_ctrl_s      = (ctrl_atual_s != ult_ctrl_q);
        dif_status_s    = ({andar, estado} != {ult_andar_q, ult_estado_q}) || pend_q;
    end

    // Next-state logic for the launch/acknowledge FSM and its bookkeeping
    always_comb begin
        fsm_d        = fsm_q;
        dados_tx_d   = dados_tx_q;
        partida_tx_d = 1'b0;
        quadros_d    = quadros_q;
        erro_d       = 1'b0;
        cnt_d        = cnt_q;
        ult_ctrl_d   = ult_ctrl_q;
        ult_andar_d  = ult_andar_q;
        ult_estado_d = ult_estado_q;
        limpa_pend_s = 1'b0;

        case (fsm_q)
            OCIOSO: begin
                cnt_d = '0;
                if (!tx_ocupado && dif_ctrl_s) begin
                    dados_tx_d   = quadro_ctrl_s;
                    partida_tx_d = 1'b1;
                    fsm_d        = ESPERA;
                end else if (!tx_ocupado && dif_status_s) begin
                    dados_tx_d   = quadro_status_s;
                    partida_tx_d = 1'b1;
                    fsm_d        = ESPERA;
                end else begin
                    fsm_d = OCIOSO;
                end
            end
            ESPERA: begin
                // Acknowledge beats a timeout landing on the same cycle
                if (pronto_tx) begin
                    fsm_d     = OCIOSO;
                    cnt_d     = '0;
                    quadros_d = quadros_q + 8'd1;
                    if (dados_tx_q[7]) begin
                        ult_ctrl_d = {dados_tx_q[4], dados_tx_q[2], dados_tx_q[0]};
                    end else begin
                        ult_andar_d  = dados_tx_q[6:4];
                        ult_estado_d = dados_tx_q[3:0];
                        limpa_pend_s = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    fsm_d  = OCIOSO;
                    cnt_d  = '0;
                    erro_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            default: begin
                fsm_d = OCIOSO;
                cnt_d = '0;
            end
        endcase

        // A request arriving on the acknowledge cycle survives the clear
        pend_d    = solicita_status | (pend_q & ~limpa_pend_s);
        ocupado_d = (fsm_d == ESPERA);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q        <= OCIOSO;
            dados_tx_q   <= 8'd0;
            partida_tx_q <= 1'b0;
            ocupado_q    <= 1'b0;
            quadros_q    <= 8'd0;
            erro_q       <= 1'b0;
            cnt_q        <= '0;
            ult_ctrl_q   <= 3'd0;
            ult_andar_q  <= 3'd0;
            ult_estado_q <= 4'd0;
            pend_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            dados_tx_q   <= dados_tx_d;
            partida_tx_q <= partida_tx_d;
            ocupado_q    <= ocupado_d;
            quadros_q    <= quadros_d;
            erro_q       <= erro_d;
            cnt_q        <= cnt_d;
            ult_ctrl_q   <= ult_ctrl_d;
            ult_andar_q  <= ult_andar_d;
            ult_estado_q <= ult_estado_d;
            pend_q       <= pend_d;
        end
    end

    assign dados_tx         = dados_tx_q;
    assign partida_tx       = partida_tx_q;
    assign ocupado          = ocupado_q;
    assign quadros_enviados = quadros_q;
    assign erro_timeout     = erro_q;

endmodule

// File: tb/tb_codificador_serial.sv
// Directed bench for codificador_serial with a short timeout so retry behaviour
// can be exercised quickly.
`timescale 1ns/1ps
module tb_codificador_serial;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       reset_sistema;
    logic       emergencia;
    logic [2:0] andar;
    logic [3:0] estado;
    logic       solicita_status;
    logic       tx_ocupado;
    logic       pronto_tx;
    logic [7:0] dados_tx;
    logic       partida_tx;
    logic       ocupado;
    logic [7:0] quadros_enviados;
    logic       erro_timeout;

    int checks;
    int failures;

    codificador_serial #(.TIMEOUT(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .reset_sistema   (reset_sistema),
        .emergencia      (emergencia),
        .andar           (andar),
        .estado          (estado),
        .solicita_status (solicita_status),
        .tx_ocupado      (tx_ocupado),
        .pronto_tx       (pronto_tx),
        .dados_tx        (dados_tx),
        .partida_tx      (partida_tx),
        .ocupado         (ocupado),
        .quadros_enviados(quadros_enviados),
        .erro_timeout    (erro_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        iniciar         = 1'b0;
        reset_sistema   = 1'b0;
        emergencia      = 1'b0;
        andar           = 3'd0;
        estado          = 4'd0;
        solicita_status = 1'b0;
        tx_ocupado      = 1'b0;
        pronto_tx       = 1'b0;

        tick(); tick();
        chk8("rst_dados", dados_tx, 8'h00);
        chk1("rst_partida", partida_tx, 1'b0);
        chk1("rst_ocupado", ocupado, 1'b0);
        chk8("rst_quadros", quadros_enviados, 8'd0);
        chk1("rst_erro", erro_timeout, 1'b0);

        reset = 1'b0;
        tick();
        chk1("idle_partida", partida_tx, 1'b0);
        chk1("idle_ocupado", ocupado, 1'b0);

        pronto_tx = 1'b1;
        tick();
        pronto_tx = 1'b0;
        chk8("pronto_idle_quadros", quadros_enviados, 8'd0);
        chk1("pronto_idle_ocupado", ocupado, 1'b0);

        // Emergency control frame
        emergencia = 1'b1;
        tick();
        chk8("emerg_dados", dados_tx, 8'h90);
        chk1("emerg_partida", partida_tx, 1'b1);
        chk1("emerg_ocupado", ocupado, 1'b1);
        tick();
        chk1("emerg_partida_1ciclo", partida_tx, 1'b0);
        chk8("emerg_dados_estavel", dados_tx, 8'h90);
        pronto_tx = 1'b1;
        tick();
        pronto_tx = 1'b0;
        chk1("emerg_ack_ocupado", ocupado, 1'b0);
        chk8("emerg_ack_quadros", quadros_enviados, 8'd1);
        tick();
        chk1("emerg_sem_reenvio", partida_tx, 1'b0);
        tick();
        chk1("emerg_ocioso", ocupado, 1'b0);

        // Control has priority over status
        reset      = 1'b1;
        emergencia = 1'b0;
        tick();
        chk8("rst2_quadros", quadros_enviados, 8'd0);
        reset   = 1'b0;
        iniciar = 1'b1;
        andar   = 3'd3;
        estado  = 4'd5;
        tick();
        chk8("prio_ctrl_dados", dados_tx, 8'h81);
        chk1("prio_ctrl_partida", partida_tx, 1'b1);
        tick();
        pronto_tx = 1'b1;
        tick();
        pronto_tx = 1'b0;
        chk8("prio_ack1_quadros", quadros_enviados, 8'd1);
        chk1("prio_ack1_ocupado", ocupado, 1'b0);
        tick();
        chk8("prio_status_dados", dados_tx, 8'h35);
        chk1("prio_status_partida", partida_tx, 1'b1);
        tick();
        pronto_tx = 1'b1;
        tick();
        pronto_tx = 1'b0;
        chk8("prio_ack2_quadros", quadros_enviados, 8'd2);
        tick();
        chk1("prio_fim_partida", partida_tx, 1'b0);
        chk1("prio_fim_ocupado", ocupado, 1'b0);

        // Forced status frames
        reset   = 1'b1;
        iniciar = 1'b0;
        andar   = 3'd0;
        estado  = 4'd0;
        tick();
        reset = 1'b0;
        tick();
        chk1("forc_ocioso", ocupado, 1'b0);
        solicita_status = 1'b1;
        tick();
        solicita_status = 1'b0;
        chk1("forc_sem_lanc_imediato", partida_tx, 1'b0);
        tick();
        chk1("forc_partida", partida_tx, 1'b1);
        chk8("forc_dados", dados_tx, 8'h00);
        chk1("forc_ocupado", ocupado, 1'b1);
        tick();
        pronto_tx       = 1'b1;
        solicita_status = 1'b1;
        tick();
        pronto_tx       = 1'b0;
        solicita_status = 1'b0;
        chk8("forc_ack1_quadros", quadros_enviados, 8'd1);
        chk1("forc_ack1_ocupado", ocupado, 1'b0);
        tick();
        chk1("forc_segundo_partida", partida_tx, 1'b1);
        tick();
        pronto_tx = 1'b1;
        tick();
        pronto_tx = 1'b0;
        chk8("forc_ack2_quadros", quadros_enviados, 8'd2);
        tick();
        chk1("forc_sem_terceiro", partida_tx, 1'b0);
        tick();
        chk1("forc_fim_ocupado", ocupado, 1'b0);

        // Transmitter busy holds off the launch
        tx_ocupado = 1'b1;
        estado     = 4'd2;
        tick();
        chk1("txocup_sem_partida", partida_tx, 1'b0);
        tick();
        chk1("txocup_ocioso", ocupado, 1'b0);
        tx_ocupado = 1'b0;
        tick();
        chk8("txocup_dados", dados_tx, 8'h02);
        chk1("txocup_partida", partida_tx, 1'b1);
        pronto_tx = 1'b1;
        tick();
        pronto_tx = 1'b0;
        chk8("txocup_quadros", quadros_enviados, 8'd3);

        // Timeout, automatic retry, acknowledge on the final cycle
        reset_sistema = 1'b1;
        tick();
        chk8("to_dados", dados_tx, 8'h84);
        chk1("to_partida", partida_tx, 1'b1);
        repeat (7) tick();
        chk1("to_ainda_ocupado", ocupado, 1'b1);
        chk1("to_sem_erro_cedo", erro_timeout, 1'b0);
        tick();
        chk1("to_erro", erro_timeout, 1'b1);
        chk1("to_ocioso", ocupado, 1'b0);
        tick();
        chk1("to_erro_1ciclo", erro_timeout, 1'b0);
        chk1("to_relanc_partida", partida_tx, 1'b1);
        chk8("to_relanc_dados", dados_tx, 8'h84);
        repeat (7) tick();
        chk1("to2_ocupado", ocupado, 1'b1);
        pronto_tx = 1'b1;
        tick();
        pronto_tx = 1'b0;
        chk1("to2_sem_erro", erro_timeout, 1'b0);
        chk1("to2_ocioso", ocupado, 1'b0);
        chk8("to2_quadros", quadros_enviados, 8'd4);
        tick();
        chk1("to2_sem_reenvio", partida_tx, 1'b0);

        // Change-and-revert while blocked produces nothing
        tx_ocupado = 1'b1;
        estado     = 4'd3;
        tick();
        estado = 4'd2;
        tick();
        tx_ocupado = 1'b0;
        tick();
        chk1("revert_sem_partida", partida_tx, 1'b0);

        // Reset in the middle of a frame
        iniciar = 1'b1;
        tick();
        chk8("mid_dados", dados_tx, 8'h85);
        chk1("mid_partida", partida_tx, 1'b1);
        tick();
        chk1("mid_ocupado", ocupado, 1'b1);
        reset = 1'b1;
        tick();
        chk8("mid_rst_dados", dados_tx, 8'h00);
        chk1("mid_rst_partida", partida_tx, 1'b0);
        chk1("mid_rst_ocupado", ocupado, 1'b0);
        chk8("mid_rst_quadros", quadros_enviados, 8'd0);
        chk1("mid_rst_erro", erro_timeout, 1'b0);
        reset         = 1'b0;
        iniciar       = 1'b0;
        reset_sistema = 1'b0;
        estado        = 4'd0;
        tick();
        chk1("mid_pos_sem_partida", partida_tx, 1'b0);
        tick();
        chk1("mid_pos_ocioso", ocupado, 1'b0);
        chk1("mid_pos_sem_erro", erro_timeout, 1'b0);
        andar = 3'd1;
        tick();
        chk8("mid_novo_dados", dados_tx, 8'h10);
        chk1("mid_novo_partida", partida_tx, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
